// File: rtl/emu_dt_sched_if.sv
// Bundle between the host control registers, the scheduler and the model instances.
// Inputs are sampled every cycle with no handshake; outputs are valid in the same cycle.
interface emu_dt_sched_if #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 25,
    parameter int TIME_WIDTH = 40
) ();
    logic [N_REQ*DT_WIDTH-1:0] dt_req;
    logic [N_REQ-1:0]          req_en;
    logic [DT_WIDTH-1:0]       ext_dt;
    logic                      run_cmd;
    logic                      step_cmd;
    logic                      stop_cmd;
    logic                      target_en;
    logic [TIME_WIDTH-1:0]     target_time;

    logic [DT_WIDTH-1:0]       emu_dt;
    logic                      emu_clk_en;
    logic [N_REQ-1:0]          winner;
    logic [TIME_WIDTH-1:0]     emu_time;
    logic [1:0]                state;
    logic                      done;
    logic                      ovf;

    modport master (
        output dt_req, req_en, ext_dt, run_cmd, step_cmd, stop_cmd, target_en, target_time,
        input  emu_dt, emu_clk_en, winner, emu_time, state, done, ovf
    );

    modport slave (
        input  dt_req, req_en, ext_dt, run_cmd, step_cmd, stop_cmd, target_en, target_time,
        output emu_dt, emu_clk_en, winner, emu_time, state, done, ovf
    );
endinterface

// File: rtl/emu_dt_sched.sv
// Common timestep scheduler: picks the smallest requested dt each cycle, gates the
// model clock enable, accumulates emulated time and runs the run/step/halt control FSM.
module emu_dt_sched #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 25,
    parameter int TIME_WIDTH = 40
) (
    input logic            clk,
    input logic            rst_n,
    emu_dt_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic [DT_WIDTH-1:0]   req_arr [N_REQ];
    logic [DT_WIDTH-1:0]   req_min;
    logic [TIME_WIDTH-1:0] rem;
    logic [DT_WIDTH-1:0]   cand;
    logic                  clk_en;
    logic [DT_WIDTH-1:0]   step_dt;
    logic [N_REQ-1:0]      winner;
    logic [TIME_WIDTH:0]   sum;
    logic                  carry;
    logic                  reached;
    logic                  at_target;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_arr[g] = bus.dt_req[g*DT_WIDTH +: DT_WIDTH];
    end

    // ext_dt is the starting bound, so a fully disabled request set falls back to it.
    always_comb begin
        req_min = bus.ext_dt;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_en[i] && (req_arr[i] < req_min)) begin
                req_min = req_arr[i];
            end
        end
    end

    always_comb begin
        rem = '0;
        if (bus.target_time > time_q) begin
            rem = bus.target_time - time_q;
        end
    end

    always_comb begin
        cand = req_min;
        if (bus.target_en && (rem < {{(TIME_WIDTH-DT_WIDTH){1'b0}}, req_min})) begin
            cand = rem[DT_WIDTH-1:0];
        end
    end

    assign clk_en  = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bus.stop_cmd;
    assign step_dt = clk_en ? cand : '0;

    always_comb begin
        winner = '0;
        if (clk_en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (bus.req_en[i] && (req_arr[i] == step_dt)) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
    end

    assign sum       = {1'b0, time_q} + {{(TIME_WIDTH+1-DT_WIDTH){1'b0}}, step_dt};
    assign carry     = clk_en && sum[TIME_WIDTH];
    assign reached   = bus.target_en && clk_en && (sum >= {1'b0, bus.target_time});
    assign at_target = bus.target_en && (time_q >= bus.target_time);

    // Command priority everywhere is stop > step > run.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        ovf_d   = ovf_q;
        done_d  = reached;

        if (clk_en) begin
            if (carry) begin
                time_d = '1;
                ovf_d  = 1'b1;
            end else begin
                time_d = sum[TIME_WIDTH-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!bus.stop_cmd) begin
                    if (bus.step_cmd) begin
                        state_d = ST_STEP;
                    end else if (bus.run_cmd) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop_cmd || reached || carry) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (bus.stop_cmd || reached || carry) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!bus.stop_cmd && !at_target) begin
                    if (bus.step_cmd) begin
                        state_d = ST_STEP;
                    end else if (bus.run_cmd) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.emu_dt     = step_dt;
    assign bus.emu_clk_en = clk_en;
    assign bus.winner     = winner;
    assign bus.emu_time   = time_q;
    assign bus.state      = state_q;
    assign bus.done       = done_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_emu_dt_sched.sv
// Directed bench for emu_dt_sched built with a 26-bit time so saturation is reachable.
module tb_emu_dt_sched;
  localparam int N_REQ      = 4;
  localparam int DT_WIDTH   = 25;
  localparam int TIME_WIDTH = 26;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  emu_dt_sched_if #(.N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH), .TIME_WIDTH(TIME_WIDTH)) bus ();

  emu_dt_sched #(.N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH), .TIME_WIDTH(TIME_WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.dt_req      = '0;
    bus.req_en      = '0;
    bus.ext_dt      = '0;
    bus.run_cmd     = 1'b0;
    bus.step_cmd    = 1'b0;
    bus.stop_cmd    = 1'b0;
    bus.target_en   = 1'b0;
    bus.target_time = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_reqs(input int r3, input int r2, input int r1, input int r0);
    bus.dt_req = {DT_WIDTH'(r3), DT_WIDTH'(r2), DT_WIDTH'(r1), DT_WIDTH'(r0)};
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", bus.state, S_IDLE);
    check("rst_time", bus.emu_time, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_clk_en", bus.emu_clk_en, 0);
    check("rst_emu_dt", bus.emu_dt, 0);
    check("rst_winner", bus.winner, 0);
    rst_n = 1'b1;
    tick();

    // 1: free run, min over four requests
    bus.req_en = 4'b1111;
    set_reqs(40, 10, 30, 20);
    bus.ext_dt = 100;
    bus.run_cmd = 1'b1;
    settle();
    check("t1_idle_clk_en", bus.emu_clk_en, 0);
    tick();
    bus.run_cmd = 1'b0;
    settle();
    check("t1_state", bus.state, S_RUN);
    check("t1_emu_dt", bus.emu_dt, 10);
    check("t1_winner", bus.winner, 4'b0100);
    check("t1_time0", bus.emu_time, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t1_time", bus.emu_time, 64'(10 * k));
      check("t1_clk_en", bus.emu_clk_en, 1);
    end
    bus.stop_cmd = 1'b1;
    settle();
    check("t1_stop_clk_en", bus.emu_clk_en, 0);
    check("t1_stop_dt", bus.emu_dt, 0);
    check("t1_stop_winner", bus.winner, 0);
    tick();
    bus.stop_cmd = 1'b0;
    check("t1_halt_state", bus.state, S_HALT);
    check("t1_halt_time", bus.emu_time, 30);

    // 2: single step driven by ext_dt only
    tick();
    do_reset();
    bus.ext_dt = 7;
    bus.step_cmd = 1'b1;
    tick();
    bus.step_cmd = 1'b0;
    settle();
    check("t2_state_step", bus.state, S_STEP);
    check("t2_clk_en", bus.emu_clk_en, 1);
    check("t2_emu_dt", bus.emu_dt, 7);
    check("t2_winner", bus.winner, 0);
    tick();
    check("t2_state_idle", bus.state, S_IDLE);
    check("t2_time", bus.emu_time, 7);
    check("t2_clk_en_off", bus.emu_clk_en, 0);
    tick();
    check("t2_time_hold", bus.emu_time, 7);

    // stop beats step in IDLE
    bus.step_cmd = 1'b1;
    bus.stop_cmd = 1'b1;
    tick();
    bus.step_cmd = 1'b0;
    bus.stop_cmd = 1'b0;
    check("t2_stop_prio", bus.state, S_IDLE);

    // 3: target stop with a clipped final step
    do_reset();
    bus.target_en = 1'b1;
    bus.target_time = 25;
    bus.req_en = 4'b1111;
    set_reqs(10, 10, 10, 10);
    bus.ext_dt = 100;
    bus.run_cmd = 1'b1;
    tick();
    bus.run_cmd = 1'b0;
    settle();
    check("t3_dt_a", bus.emu_dt, 10);
    check("t3_winner_a", bus.winner, 4'b0001);
    tick();
    check("t3_dt_b", bus.emu_dt, 10);
    check("t3_time_b", bus.emu_time, 10);
    tick();
    check("t3_dt_c", bus.emu_dt, 5);
    check("t3_winner_c", bus.winner, 0);
    check("t3_done_early", bus.done, 0);
    tick();
    check("t3_time_end", bus.emu_time, 25);
    check("t3_state_halt", bus.state, S_HALT);
    check("t3_done", bus.done, 1);
    bus.run_cmd = 1'b1;
    settle();
    check("t3_halt_clk_en", bus.emu_clk_en, 0);
    tick();
    bus.run_cmd = 1'b0;
    check("t3_run_ignored", bus.state, S_HALT);
    check("t3_done_pulse", bus.done, 0);
    check("t3_time_frozen", bus.emu_time, 25);

    // raised target resumes; then target dropped below time mid-run
    bus.target_time = 45;
    bus.run_cmd = 1'b1;
    tick();
    bus.run_cmd = 1'b0;
    settle();
    check("t3_resume_state", bus.state, S_RUN);
    check("t3_resume_dt", bus.emu_dt, 10);
    tick();
    check("t3_resume_time", bus.emu_time, 35);
    bus.target_time = 30;
    settle();
    check("t3_rem0_dt", bus.emu_dt, 0);
    check("t3_rem0_clk_en", bus.emu_clk_en, 1);
    tick();
    check("t3_rem0_state", bus.state, S_HALT);
    check("t3_rem0_done", bus.done, 1);
    check("t3_rem0_time", bus.emu_time, 35);

    // 4: run and stop together while running
    do_reset();
    bus.req_en = 4'b0001;
    set_reqs(0, 0, 0, 3);
    bus.ext_dt = 100;
    bus.run_cmd = 1'b1;
    tick();
    bus.run_cmd = 1'b0;
    tick();
    check("t4_time_run", bus.emu_time, 3);
    bus.run_cmd = 1'b1;
    bus.stop_cmd = 1'b1;
    settle();
    check("t4_clk_en", bus.emu_clk_en, 0);
    check("t4_emu_dt", bus.emu_dt, 0);
    tick();
    bus.run_cmd = 1'b0;
    bus.stop_cmd = 1'b0;
    check("t4_state", bus.state, S_HALT);
    tick();
    check("t4_time_frozen", bus.emu_time, 3);

    // 5: saturation of the 26-bit time
    do_reset();
    bus.ext_dt = 25'h1FF_FFFF;
    bus.run_cmd = 1'b1;
    tick();
    bus.run_cmd = 1'b0;
    tick();
    check("t5_time_1", bus.emu_time, 64'h1FF_FFFF);
    tick();
    check("t5_time_2", bus.emu_time, 64'h3FF_FFFE);
    check("t5_ovf_pre", bus.ovf, 0);
    tick();
    check("t5_time_sat", bus.emu_time, 64'h3FF_FFFF);
    check("t5_ovf", bus.ovf, 1);
    check("t5_state", bus.state, S_HALT);
    tick();
    check("t5_ovf_sticky", bus.ovf, 1);

    // 6: asynchronous reset in the middle of a run
    do_reset();
    bus.ext_dt = 5;
    bus.run_cmd = 1'b1;
    tick();
    bus.run_cmd = 1'b0;
    tick();
    check("t6_time_run", bus.emu_time, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_clk_en", bus.emu_clk_en, 0);
    check("t6_time", bus.emu_time, 0);
    check("t6_state", bus.state, S_IDLE);
    rst_n = 1'b1;
    tick();

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
